// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and column helpers for the keypad scanner
package keypad_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam int CODE_W   = 4;

    typedef logic [CODE_W-1:0] key_code_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } kp_state_t;

    // Number of low (pressed) column lines, saturating at 2 since 2+ is all ghost logic cares about
    function automatic logic [1:0] count_low(input logic [KEY_COLS-1:0] col_n);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < KEY_COLS; i++) begin
            if (!col_n[i] && n != 2'd2) begin
                n = n + 2'd1;
            end
        end
        return n;
    endfunction

    // Index of the lowest-numbered low column line (only meaningful when exactly one is low)
    function automatic logic [1:0] first_low(input logic [KEY_COLS-1:0] col_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = KEY_COLS - 1; i >= 0; i--) begin
            if (!col_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and accepted-key outputs
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KEY_COLS-1:0] key_col;
    logic [KEY_ROWS-1:0] key_row;
    key_code_t           key_code;
    logic                key_valid;
    logic                key_held;

    // Scanner side: senses columns, drives rows and reports keys
    modport master (
        input  key_col,
        output key_row,
        output key_code,
        output key_valid,
        output key_held
    );

    // Keypad/consumer side
    modport slave (
        output key_col,
        input  key_row,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner_tick_gen.sv
// rtl/keypad_scanner_tick_gen.sv - one-cycle enable pulse every SCAN_DIV clocks
module scan_tick_gen #(
    parameter int SCAN_DIV = 2500
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int                CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    // Free-running prescaler that wraps on the tick cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low keypad scanner with scan-level debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 2500,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clock,
    input  logic               reset,
    keypad_scanner_if.master   kp
);
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_SCANS);

    logic [KEY_COLS-1:0] col_meta, col_sync;
    logic                tick;
    logic [1:0]          row_idx;
    logic [KEY_ROWS-1:0] row_drive;

    logic [1:0] hits_acc;
    key_code_t  single_acc;
    logic       cand_hit_acc;

    logic [1:0] row_hits;
    logic [2:0] hits_sum;
    logic [1:0] scan_hits;
    key_code_t  scan_single;
    logic       scan_cand_hit;
    logic       eos;
    logic       is_single;

    kp_state_t  state, state_next;
    key_code_t  cand, cand_next;
    logic [3:0] cnt, cnt_next, cnt_inc;
    logic       accept, release_key;

    key_code_t  code_q;
    logic       valid_q, held_q;

    // Column lines are asynchronous to the clock; two flops before use
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_meta <= 4'b1111;
            col_sync <= 4'b1111;
        end else begin
            col_meta <= kp.key_col;
            col_sync <= col_meta;
        end
    end

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Step to the next row after each tick has sampled the current one
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_idx   <= 2'd0;
            row_drive <= 4'b1110;
        end else if (tick) begin
            row_idx   <= row_idx + 2'd1;
            row_drive <= ~(4'b0001 << (row_idx + 2'd1));
        end
    end

    assign kp.key_row = row_drive;

    // Scan view including the row being sampled this cycle
    always_comb begin
        row_hits      = count_low(col_sync);
        hits_sum      = {1'b0, hits_acc} + {1'b0, row_hits};
        scan_hits     = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
        scan_single   = (hits_acc == 2'd0 && row_hits == 2'd1) ? {row_idx, first_low(col_sync)}
                                                               : single_acc;
        scan_cand_hit = cand_hit_acc | ((row_idx == cand[3:2]) && !col_sync[cand[1:0]]);
        eos           = tick && (row_idx == 2'd3);
        is_single     = (scan_hits == 2'd1);
    end

    // Per-scan accumulators; cleared once the row-3 sample has been evaluated
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hits_acc     <= 2'd0;
            single_acc   <= '0;
            cand_hit_acc <= 1'b0;
        end else if (eos) begin
            hits_acc     <= 2'd0;
            single_acc   <= '0;
            cand_hit_acc <= 1'b0;
        end else if (tick) begin
            hits_acc     <= scan_hits;
            single_acc   <= scan_single;
            cand_hit_acc <= scan_cand_hit;
        end
    end

    // Debounce state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cand  <= '0;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
        end
    end

    // Debounce transitions, only evaluated when a full scan completes
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        cnt_inc    = cnt + 4'd1;
        if (eos) begin
            case (state)
                ST_IDLE: begin
                    if (is_single) begin
                        cand_next = scan_single;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next = ST_HELD;
                            cnt_next   = 4'd0;
                        end else begin
                            state_next = ST_PRESS_DB;
                            cnt_next   = 4'd1;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (is_single && scan_single == cand) begin
                        if (cnt_inc == DB_LAST) begin
                            state_next = ST_HELD;
                            cnt_next   = 4'd0;
                        end else begin
                            cnt_next   = cnt_inc;
                        end
                    end else if (is_single) begin
                        cand_next = scan_single;
                        cnt_next  = 4'd1;
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = 4'd0;
                    end
                end
                ST_HELD: begin
                    if (!scan_cand_hit) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next = ST_IDLE;
                            cnt_next   = 4'd0;
                        end else begin
                            state_next = ST_REL_DB;
                            cnt_next   = 4'd1;
                        end
                    end
                end
                ST_REL_DB: begin
                    if (scan_cand_hit) begin
                        state_next = ST_HELD;
                        cnt_next   = 4'd0;
                    end else if (cnt_inc == DB_LAST) begin
                        state_next = ST_IDLE;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next   = cnt_inc;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    // Acceptance and release events derived from the transition being taken
    always_comb begin
        accept      = 1'b0;
        release_key = 1'b0;
        if (eos) begin
            accept      = (state == ST_IDLE || state == ST_PRESS_DB) && (state_next == ST_HELD);
            release_key = (state == ST_HELD || state == ST_REL_DB) && (state_next == ST_IDLE);
        end
    end

    // Registered key outputs; key_code keeps the last accepted key after release
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                code_q <= cand_next;
                held_q <= 1'b1;
            end else if (release_key) begin
                held_q <= 1'b0;
            end
        end
    end

    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized and directed bench for keypad_scanner
module tb_keypad_scanner;
    localparam int SCAN_DIV  = 4;
    localparam int DB        = 3;
    localparam int SCAN_CLKS = 4 * SCAN_DIV;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
        .clock (clock),
        .reset (reset),
        .kp    (kif.master)
    );

    logic [15:0] pressed = 16'h0000;
    logic [3:0]  kcol;

    // Physical keypad: a column reads low when a pressed key sits on a driven row
    always_comb begin
        kcol = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kif.key_row[r] && pressed[r*4+c]) kcol[c] = 1'b0;
            end
        end
    end
    assign kif.key_col = kcol;

    int vectors    = 0;
    int miscompares = 0;

    // Reference: "accepted" key with run lengths of matching / missing scans
    bit       m_accepted;
    int       m_cand;
    int       m_press_run;
    int       m_miss_run;
    logic [3:0] m_code;

    task automatic model_reset();
        m_accepted  = 0;
        m_cand      = 0;
        m_press_run = 0;
        m_miss_run  = 0;
        m_code      = 4'd0;
    endtask

    task automatic model_scan(input logic [15:0] mask, output bit fire);
        int n, k;
        fire = 0;
        n = $countones(mask);
        k = 0;
        for (int i = 15; i >= 0; i--) if (mask[i]) k = i;
        if (!m_accepted) begin
            if (n == 1) begin
                if (m_press_run > 0 && k == m_cand) m_press_run++;
                else begin
                    m_cand = k;
                    m_press_run = 1;
                end
                if (m_press_run == DB) begin
                    m_accepted  = 1;
                    m_code      = 4'(m_cand);
                    m_press_run = 0;
                    m_miss_run  = 0;
                    fire        = 1;
                end
            end else begin
                m_press_run = 0;
            end
        end else begin
            if (mask[m_cand]) m_miss_run = 0;
            else begin
                m_miss_run++;
                if (m_miss_run == DB) begin
                    m_accepted = 0;
                    m_miss_run = 0;
                end
            end
        end
    endtask

    // Hold one key mask for a full scan and check every cycle of it
    task automatic do_scan(input logic [15:0] mask);
        bit         fire;
        logic       held_before, exp_held, exp_valid;
        logic [3:0] code_before, exp_code, exp_row;
        held_before = m_accepted;
        code_before = m_code;
        pressed = mask;
        model_scan(mask, fire);
        for (int i = 1; i <= SCAN_CLKS; i++) begin
            @(posedge clock);
            #1;
            exp_row = 4'b1111;
            exp_row[(i / SCAN_DIV) % 4] = 1'b0;
            exp_valid = (i == SCAN_CLKS) && fire;
            exp_held  = (i == SCAN_CLKS) ? m_accepted : held_before;
            exp_code  = (i == SCAN_CLKS) ? m_code : code_before;
            vectors++;
            if (kif.key_row !== exp_row) begin
                miscompares++;
                $display("FAIL key_row: got %b expected %b (cycle %0d)", kif.key_row, exp_row, i);
            end
            vectors++;
            if (kif.key_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL key_valid: got %b expected %b (cycle %0d, mask %h)", kif.key_valid, exp_valid, i, mask);
            end
            vectors++;
            if (kif.key_held !== exp_held) begin
                miscompares++;
                $display("FAIL key_held: got %b expected %b (cycle %0d, mask %h)", kif.key_held, exp_held, i, mask);
            end
            vectors++;
            if (kif.key_code !== exp_code) begin
                miscompares++;
                $display("FAIL key_code: got %0d expected %0d (cycle %0d, mask %h)", kif.key_code, exp_code, i, mask);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (kif.key_row !== 4'b1110 || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0 || kif.key_code !== 4'd0) begin
            miscompares++;
            $display("FAIL %s: got row=%b valid=%b held=%b code=%0d expected row=1110 valid=0 held=0 code=0",
                     tag, kif.key_row, kif.key_valid, kif.key_held, kif.key_code);
        end
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pressed = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset_state");
        release_reset();
    endtask

    task automatic test_idle_scan();
        repeat (2) do_scan(16'h0000);
    endtask

    task automatic test_single_press();
        repeat (6) do_scan(16'h0001 << 9);
        repeat (3) do_scan(16'h0000);
    endtask

    task automatic test_bounce();
        repeat (3) begin
            do_scan(16'h0001 << 9);
            do_scan(16'h0000);
        end
        repeat (4) do_scan(16'h0001 << 9);
        repeat (3) do_scan(16'h0000);
    endtask

    task automatic test_ghost();
        repeat (2) do_scan(16'h0021);
        repeat (3) do_scan(16'h0001);
        repeat (3) do_scan(16'h0000);
    endtask

    task automatic test_rollover();
        repeat (3) do_scan(16'h0008);
        repeat (2) do_scan(16'h1008);
        repeat (3) do_scan(16'h1000);
        do_scan(16'h0000);
        repeat (3) do_scan(16'h1000);
        repeat (3) do_scan(16'h0000);
    endtask

    task automatic test_reset_abort();
        do_scan(16'h0001 << 9);
        pressed = 16'h0001 << 9;
        repeat (SCAN_CLKS / 2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_abort");
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset_hold");
        release_reset();
        repeat (4) do_scan(16'h0001 << 9);
        repeat (3) do_scan(16'h0000);
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int sel;
        mask = 16'h0000;
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 9);
            if (sel >= 4 && sel <= 5) mask = 16'h0000;
            else if (sel >= 6 && sel <= 8) mask = 16'h0001 << $urandom_range(0, 15);
            else if (sel == 9) mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            do_scan(mask);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_scan();
        test_single_press();
        test_bounce();
        test_ghost();
        test_rollover();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
